// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one registered ALU between two requesters.
// Optional ALU_SHARE_ARB_B2B_EN: re-arbitrate in RESP on the response handshake (RESP->EXEC).
module alu_share_arb #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  // requester 0: integer issue stage
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_op1,
  input  logic [XLEN-1:0]  req0_op2,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic             req0_imm,
  input  logic [TAG_W-1:0] req0_tag,
  // requester 1: address/branch helper
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_op1,
  input  logic [XLEN-1:0]  req1_op2,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic             req1_imm,
  input  logic [TAG_W-1:0] req1_tag,
  // shared ALU
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic             alu_imm,
  input  logic [XLEN-1:0]  alu_res,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  typedef struct packed {
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             imm;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_grant_q;
  logic   grant_c;
  logic   arb_en_c;
  logic   accept_c;
  req_t   req0_pl;
  req_t   req1_pl;
  req_t   sel_pl;

  assign req0_pl = {req0_op1, req0_op2, req0_funct3, req0_funct7, req0_imm, req0_tag};
  assign req1_pl = {req1_op1, req1_op2, req1_funct3, req1_funct7, req1_imm, req1_tag};

  // Round-robin pick: a lone requester wins, contention goes to the port not granted last.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign sel_pl = grant_c ? req1_pl : req0_pl;

  // Next-state and arbitration window.
  always_comb begin
    state_d  = state_q;
    arb_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en_c = 1'b1;
        if (req0_valid || req1_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
`ifdef ALU_SHARE_ARB_B2B_EN
          arb_en_c = 1'b1;
          if (req0_valid || req1_valid) begin
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept_c = arb_en_c && (req0_valid || req1_valid);

  // Readies are forced low while reset is asserted even though the FSM sits in IDLE.
  assign req0_ready = RST_N && arb_en_c && req0_valid && !grant_c;
  assign req1_ready = RST_N && arb_en_c && req1_valid &&  grant_c;

  // The ALU result register is read straight through; alu_* are held so it stays stable.
  assign rsp_data = alu_res;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= (state_d == RESP);
      busy      <= (state_d != IDLE);
      if (accept_c) begin
        last_grant_q <= grant_c;
      end
    end
  end

  // Operand/control and response-id capture on the accepting edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_funct3 <= 3'd0;
      alu_funct7 <= 7'd0;
      alu_imm    <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
    end else if (accept_c) begin
      alu_op1    <= sel_pl.op1;
      alu_op2    <= sel_pl.op2;
      alu_funct3 <= sel_pl.funct3;
      alu_funct7 <= sel_pl.funct7;
      alu_imm    <= sel_pl.imm;
      rsp_id     <= grant_c;
      rsp_tag    <= sel_pl.tag;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with a behavioural ALU and a transaction-level model.
module tb_alu_share_arb;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 4;
`ifdef ALU_SHARE_ARB_B2B_EN
  localparam bit B2B     = 1'b1;
  localparam int SPACING = 2;
`else
  localparam bit B2B     = 1'b0;
  localparam int SPACING = 3;
`endif

  logic             CLK;
  logic             RST_N;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [XLEN-1:0]  req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]       req0_funct3, req1_funct3;
  logic [6:0]       req0_funct7, req1_funct7;
  logic             req0_imm, req1_imm;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [XLEN-1:0]  alu_op1, alu_op2, alu_res;
  logic [2:0]       alu_funct3;
  logic [6:0]       alu_funct7;
  logic             alu_imm;
  logic             rsp_valid, rsp_ready, rsp_id, busy;
  logic [XLEN-1:0]  rsp_data;
  logic [TAG_W-1:0] rsp_tag;

  alu_share_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_imm(req0_imm), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_imm(req1_imm), .req1_tag(req1_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_imm(alu_imm), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  typedef struct {
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             imm;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
  } op_t;

  typedef struct {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } rsp_t;

  op_t  q0[$];
  op_t  q1[$];
  rsp_t sb[$];
  bit   grant_log[$];
  int   acc_cyc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int age = 0;
  int rr_mode = 1;
  bit outst = 1'b0;
  bit lg = 1'b1;
  bit last_acc = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RV-style integer ALU semantics.
  function automatic logic [XLEN-1:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic imm);
    logic [5:0] sh;
    sh = b[5:0];
    case (f3)
      3'd0:    return (f7[5] && !imm) ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3:    return (a < b) ? 64'd1 : 64'd0;
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? 64'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // One-cycle registered ALU standing in for the real instance.
  always_ff @(posedge CLK) alu_res <= ref_alu(alu_op1, alu_op2, alu_funct3, alu_funct7, alu_imm);

  function automatic op_t mk_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                                input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp);
    op_t o;
    o.op1 = a; o.op2 = b; o.f3 = f3; o.f7 = f7; o.imm = imm; o.tag = tag; o.exp = exp;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.op1 = {$urandom, $urandom};
    o.op2 = {$urandom, $urandom};
    o.f3  = 3'($urandom_range(0, 7));
    o.f7  = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    o.imm = 1'($urandom_range(0, 1));
    o.tag = TAG_W'($urandom_range(0, 15));
    o.exp = ref_alu(o.op1, o.op2, o.f3, o.f7, o.imm);
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    op_t z;
    z = mk_op(64'd0, 64'd0, 3'd0, 7'd0, 1'b0, 4'd0, 64'd0);
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (q0.size() != 0) z = q0[0];
    req0_op1 = z.op1; req0_op2 = z.op2; req0_funct3 = z.f3; req0_funct7 = z.f7;
    req0_imm = z.imm; req0_tag = z.tag;
    z = mk_op(64'd0, 64'd0, 3'd0, 7'd0, 1'b0, 4'd0, 64'd0);
    if (q1.size() != 0) z = q1[0];
    req1_op1 = z.op1; req1_op2 = z.op2; req1_funct3 = z.f3; req1_funct7 = z.f7;
    req1_imm = z.imm; req1_tag = z.tag;
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic model_reset();
    sb.delete();
    outst = 1'b0;
    age   = 0;
    lg    = 1'b1;
  endtask

  task automatic chk_reset();
    chk("rst_alu_op1", alu_op1, 64'd0);
    chk("rst_alu_op2", alu_op2, 64'd0);
    chk("rst_alu_funct3", 64'(alu_funct3), 64'd0);
    chk("rst_alu_funct7", 64'(alu_funct7), 64'd0);
    chk("rst_alu_imm", 64'(alu_imm), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
  endtask

  // One clock: check handshake/timing at negedge, update model, then drive after posedge.
  task automatic step();
    bit v0, v1, win, free, exp_rv, hs, acc;
    op_t op;
    @(negedge CLK);
    cyc++;
    if (outst) age++;
    v0     = req0_valid;
    v1     = req1_valid;
    exp_rv = RST_N && outst && (age >= 2);
    hs     = exp_rv && rsp_ready;
    free   = RST_N && (!outst || (B2B && hs));
    win    = (v0 && v1) ? ~lg : v1;
    acc    = free && (v0 || v1);
    chk("req0_ready", 64'(req0_ready), 64'(acc && !win));
    chk("req1_ready", 64'(req1_ready), 64'(acc && win));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("busy", 64'(busy), 64'(RST_N && outst));
    last_acc = acc;
    if (hs) outst = 1'b0;
    if (acc) begin
      op = win ? q1[0] : q0[0];
      sb.push_back('{id: win, tag: op.tag, data: op.exp});
      grant_log.push_back(win);
      acc_cyc.push_back(cyc);
      lg    = win;
      outst = 1'b1;
      age   = 0;
    end
    @(posedge CLK);
    #1;
    if (acc) begin
      if (win) void'(q1.pop_front());
      else     void'(q0.pop_front());
    end
    drive();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || outst || sb.size() != 0) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: q0=%0d q1=%0d sb=%0d still pending", q0.size(), q1.size(), sb.size());
    end
  endtask

  // Response monitor: every presented response must match the scoreboard head.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && rsp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp @cyc %0d: got data %0h id %0d tag %0h with none expected",
                   cyc, rsp_data, rsp_id, rsp_tag);
        end else begin
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
          chk("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ord[4];
    ord = '{0, 1, 0, 1};
    RST_N   = 1'b1;
    rr_mode = 1;
    // contention ops: port 0 SUB 10-3, port 1 XOR 0xF0^0xFF
    q0.push_back(mk_op(64'd10, 64'd3, 3'd0, 7'h20, 1'b0, 4'd1, 64'd7));
    q0.push_back(mk_op(64'd10, 64'd3, 3'd0, 7'h20, 1'b0, 4'd2, 64'd7));
    q1.push_back(mk_op(64'hF0, 64'hFF, 3'd4, 7'h00, 1'b0, 4'd5, 64'h0F));
    q1.push_back(mk_op(64'hF0, 64'hFF, 3'd4, 7'h00, 1'b0, 4'd6, 64'h0F));
    drive();
    #1 RST_N = 1'b0;
    model_reset();
    #1 chk_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    // contention straight after reset
    grant_log.delete();
    drain();
    chk("grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < grant_log.size() && k < 4; k++) chk("grant_order", 64'(grant_log[k]), 64'(ord[k]));

    // single op: ADD 5+7
    q0.push_back(mk_op(64'd5, 64'd7, 3'd0, 7'h00, 1'b0, 4'd3, 64'd12));
    drain();

    // back-pressure: hold rsp_ready low in RESP with both requesters pending
    rr_mode = 0;
    rsp_ready = 1'b0;
    q0.push_back(mk_op(64'd100, 64'd23, 3'd0, 7'h00, 1'b0, 4'd7, 64'd123));
    for (int k = 0; k < 10 && !(outst && age >= 2); k++) step();
    q0.push_back(mk_op(64'hAA, 64'h0F, 3'd6, 7'h00, 1'b0, 4'd8, 64'hAF));
    q1.push_back(mk_op(64'hAA, 64'h0F, 3'd7, 7'h00, 1'b0, 4'd9, 64'h0A));
    n = acc_cyc.size();
    for (int k = 0; k < 5; k++) step();
    chk("bp_no_accept", 64'(acc_cyc.size()), 64'(n));
    rr_mode = 1;
    drain();

    // back-to-back spacing on port 1
    acc_cyc.delete();
    for (int k = 0; k < 6; k++) q1.push_back(rand_op());
    drain();
    chk("b2b_accepts", 64'(acc_cyc.size()), 64'd6);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("b2b_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(SPACING));

    // reset while the op is in EXEC
    q0.push_back(rand_op());
    for (int k = 0; k < 10 && !last_acc; k++) step();
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    drive();
    RST_N = 1'b0;
    model_reset();
    #1 chk_reset();
    step();
    step();
    RST_N = 1'b1;
    grant_log.delete();
    drain();
    if (grant_log.size() > 0) chk("post_reset_first_grant", 64'(grant_log[0]), 64'd0);
    else chk("post_reset_grants", 64'(grant_log.size()), 64'd2);

    // randomized traffic with random back-pressure
    rr_mode = 2;
    for (int k = 0; k < 400; k++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      step();
    end
    rr_mode = 1;
    drain();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares the single registered 64-bit ALU between two requesters (port 0: integer issue stage, port 1: address/branch helper). Accepts one operation at a time through a valid/ready handshake, drives and holds the ALU operand/function inputs, waits out the ALU's one-cycle registered latency, and returns the result with the requester id and tag on a shared response channel. Sits between the issue logic and the `alu` instance.

## Interface
- XLEN, 64, operand/result width; must match the ALU.
- TAG_W, 4, opaque requester tag returned with the result.

- CLK  in  1  clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present; must hold stable with its payload until ready.
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid.
- reqN_op1, reqN_op2  in  XLEN  operands.
- reqN_funct3  in  3  ALU function select.
- reqN_funct7  in  7  ALU function modifier.
- reqN_imm  in  1  immediate form; suppresses SUB.
- reqN_tag  in  TAG_W  returned unchanged.
- alu_op1, alu_op2  out  XLEN  registered ALU operands.
- alu_funct3 / alu_funct7 / alu_imm  out  3 / 7 / 1  registered ALU controls.
- alu_res  in  XLEN  ALU registered result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  XLEN  equals alu_res while rsp_valid.
- rsp_id  out  1  requester that issued the operation.
- rsp_tag  out  TAG_W  tag of that operation.
- busy  out  1  high in EXEC or RESP.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one; the granted req ready is high combinationally, the other is low. On the accepting edge, latch payload into alu_* regs, rsp_id, rsp_tag; go to EXEC.
- Arbitration: round-robin on last_grant. Only one valid: it wins. Both valid: the requester ≠ last_grant wins. last_grant updates on every accept. Reset value of last_grant = 1, so port 0 wins first contention.
- EXEC: one cycle; the ALU samples the held alu_* inputs. Always proceeds to RESP.
- RESP: rsp_valid = 1, rsp_data = alu_res. alu_* regs held unchanged, so alu_res stays stable. On rsp_valid && rsp_ready, leave RESP (see Configuration).
- Both req ready outputs are 0 in EXEC, 0 in RESP except the back-to-back case, and 0 while RST_N low.
- No payload changes or funct decoding inside this block; encodings pass through bit-exact.
- A requester dropping valid before ready is a protocol violation; behaviour is unspecified.

## Timing
- Reset (async assert, synchronous-safe deassert by upstream): state IDLE; alu_op1 = alu_op2 = 0, alu_funct3 = 0, alu_funct7 = 0, alu_imm = 0; rsp_valid = 0, rsp_id = 0, rsp_tag = 0; busy = 0; req0_ready = req1_ready = 0; last_grant = 1.
- Accept at edge E0; ALU registers result at E1; rsp_valid high from E1 through the edge where rsp_ready is sampled high. Minimum request-to-response latency is 2 cycles.
- Throughput without back-to-back is one op per 3 cycles with rsp_ready tied high; with back-to-back it is one op per 2 cycles.
- Reset mid-EXEC/RESP: the in-flight op is discarded and no response is produced; after release the FSM starts in IDLE.
- rsp_ready held low: stall indefinitely in RESP; rsp_data, rsp_id, rsp_tag stable.

## Configuration
- ALU_SHARE_ARB_B2B_EN defined: in RESP, when rsp_ready is high, the arbiter also arbitrates the pending requests in the same cycle. A grant accepts on that edge and goes RESP→EXEC; with no valid request it goes RESP→IDLE.
- Not defined: RESP→IDLE always, so every op is followed by one idle bubble. Req ready is never high in RESP.

## Test plan
- Single op: req0 ADD op1=5, op2=7, tag=3, rsp_ready=1 → rsp_valid exactly 2 cycles after accept, rsp_data=12, rsp_id=0, rsp_tag=3.
- Contention: both valid continuously after reset, port 0 SUB 10−3 and port 1 XOR 0xF0^0xFF → grant order 0,1,0,1; responses 7 and 0x0F with matching ids and tags.
- Back-pressure: rsp_ready low for 5 cycles in RESP → rsp_valid/data/id/tag constant, both req ready low, no new accept; accept resumes after the handshake.
- Back-to-back: continuous req1 traffic with rsp_ready=1 → accepts spaced 2 cycles with B2B_EN, 3 cycles without.
- Reset in EXEC: assert RST_N low one cycle after accept → outputs reach reset values immediately, no rsp_valid after release; next contention grants port 0.
